hex_segment_reader: RTL
=======================

// Module: hex_segment_reader
// PURPOSE
//   Reverse path of the board's 7-segment display decode: samples a bank of active-low 7-segment
//   patterns (DE1-SoC HEX0..HEX5 style), waits until they are stable, then scans them one digit
//   per cycle and recovers the 4-bit hex value of each digit. Used for display readback and
//   loopback self-check of the annealer's status display path.
// PARAMETERS
//   NUM_DIGITS      6     number of 7-seg digits on seg_in (digit 0 = seg_in[6:0])
//   STABLE_CYCLES   4     consecutive unchanged cycles required before scanning (>=1)
//   TIMEOUT_CYCLES  1023  max cycles spent waiting for stability before abort (>STABLE_CYCLES)
// PORTS
//   clk         in   1              system clock, all logic rising-edge
//   rst_n       in   1              asynchronous, active-low reset
//   start       in   1              request a readback; sampled only in IDLE
//   seg_in      in   7*NUM_DIGITS   active-low segment patterns, bit order g..a per digit
//   busy        out  1              high from cycle after accepted start through last SCAN cycle
//   done        out  1              one-cycle pulse; outputs below valid from this cycle on
//   value       out  4*NUM_DIGITS   decoded nibbles, digit i at value[4i+3:4i]
//   valid_mask  out  NUM_DIGITS     bit i = digit i held a legal hex pattern
//   error       out  1              any digit held an illegal (non-hex, non-blank) pattern, or timeout
//   timeout     out  1              stability not reached within TIMEOUT_CYCLES
// BEHAVIOUR
//   - Reset (async, rst_n=0): state IDLE; busy, done, value, valid_mask, error, timeout all 0;
//     snapshot, stability counter, timeout counter, digit index cleared. Reset mid-operation aborts
//     silently: no done pulse, outputs zero.
//   - States: IDLE -> STABLE -> SCAN -> DONE -> IDLE.
//   - IDLE: start=1 at edge T -> snapshot<=seg_in, stab_cnt<=0, to_cnt<=0, state STABLE.
//     start in any other state is ignored (no queueing).
//   - STABLE, each edge: to_cnt++; if seg_in==snapshot, stab_cnt++, and when stab_cnt reaches
//     STABLE_CYCLES-1 go SCAN (idx<=0); else snapshot<=seg_in, stab_cnt<=0.
//     If to_cnt reaches TIMEOUT_CYCLES-1 first: go DONE with timeout=1, error=1, value=0, mask=0.
//   - SCAN: one digit per edge, idx 0..NUM_DIGITS-1, decoding snapshot (not live seg_in).
//     Table: 40->0 79->1 24->2 30->3 19->4 12->5 02->6 78->7 00->8 10->9 08->A 03->b
//     46->C 21->d 06->E 0E->F. 7F (blank): nibble 0, mask bit 0, no error.
//     Any other pattern: nibble 0, mask bit 0, sticky error bit set. After idx NUM_DIGITS-1 -> DONE.
//   - DONE (one cycle): done=1, busy=0; value/valid_mask/error/timeout committed atomically from
//     shadow registers and held until the next accepted start's DONE or reset. Then IDLE.
//   - Latency, stable input: start sampled at edge T -> done high after edge T+1+STABLE_CYCLES+NUM_DIGITS
//     (11 edges at defaults). Each snapshot change restarts stab_cnt, adding latency.
//   - start high during DONE is ignored; start held high continuously re-triggers on each IDLE visit.
//   - Counters sized $clog2(TIMEOUT_CYCLES+1); no wrap possible before timeout exit.
// TESTING
//   1. seg_in HEX5..HEX0 = 79,24,30,19,12,02 static; pulse start -> done 11 edges later,
//      value=24'h123456, valid_mask=6'h3F, error=0, timeout=0; busy high 10 cycles.
//   2. All digits = 7F -> value=0, valid_mask=0, error=0.
//   3. Digit 2 = 7E (illegal), rest 40 -> value=0, valid_mask=6'h3B, error=1.
//   4. Change digit 0 from 40 to 79 two edges after start -> done delayed to edge 13, value digit0=1.
//   5. seg_in toggles every cycle, TIMEOUT_CYCLES=16 -> done at edge T+17, timeout=1, error=1, value=0.
//   6. Assert rst_n=0 during SCAN -> all outputs 0 immediately, no done; a following start completes normally.

Source files
------------

// File: rtl/hex_segment_reader.sv
// Recovers hex nibbles from a bank of active-low 7-segment patterns once they hold stable; done follows start by 1+STABLE_CYCLES+NUM_DIGITS edges.
// No backpressure: start is taken only in IDLE, and results hold until the next completed readback.
module hex_segment_reader #(
  parameter int NUM_DIGITS     = 6,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic [7*NUM_DIGITS-1:0] i_seg_in,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [4*NUM_DIGITS-1:0] o_value,
  output logic [NUM_DIGITS-1:0]   o_valid_mask,
  output logic                    o_error,
  output logic                    o_timeout
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] ST_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STABLE = 2'd1;
  localparam logic [1:0] S_SCAN   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]              r_state;
  logic [7*NUM_DIGITS-1:0] r_snap;
  logic [CW-1:0]           r_stab_cnt;
  logic [CW-1:0]           r_to_cnt;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_sh_value;
  logic [NUM_DIGITS-1:0]   r_sh_mask;
  logic                    r_sh_err;
  logic                    r_sh_to;
  logic                    r_busy;
  logic                    r_done;
  logic [4*NUM_DIGITS-1:0] r_value;
  logic [NUM_DIGITS-1:0]   r_valid_mask;
  logic                    r_error;
  logic                    r_timeout;

  logic [6:0] w_pat;
  logic [3:0] w_nib;
  logic       w_legal;
  logic       w_blank;

  // Decode from the snapshot so a late glitch on the live pins cannot tear the scan.
  always_comb begin
    w_pat   = r_snap[r_idx*7 +: 7];
    w_nib   = 4'h0;
    w_legal = 1'b1;
    w_blank = 1'b0;
    case (w_pat)
      7'h40: w_nib = 4'h0;
      7'h79: w_nib = 4'h1;
      7'h24: w_nib = 4'h2;
      7'h30: w_nib = 4'h3;
      7'h19: w_nib = 4'h4;
      7'h12: w_nib = 4'h5;
      7'h02: w_nib = 4'h6;
      7'h78: w_nib = 4'h7;
      7'h00: w_nib = 4'h8;
      7'h10: w_nib = 4'h9;
      7'h08: w_nib = 4'hA;
      7'h03: w_nib = 4'hB;
      7'h46: w_nib = 4'hC;
      7'h21: w_nib = 4'hD;
      7'h06: w_nib = 4'hE;
      7'h0E: w_nib = 4'hF;
      7'h7F: begin
        w_legal = 1'b0;
        w_blank = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_snap       <= '0;
      r_stab_cnt   <= '0;
      r_to_cnt     <= '0;
      r_idx        <= '0;
      r_sh_value   <= '0;
      r_sh_mask    <= '0;
      r_sh_err     <= 1'b0;
      r_sh_to      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_value      <= '0;
      r_valid_mask <= '0;
      r_error      <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_busy <= (r_state == S_STABLE) || (r_state == S_SCAN);
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_snap     <= i_seg_in;
            r_stab_cnt <= '0;
            r_to_cnt   <= '0;
            r_sh_value <= '0;
            r_sh_mask  <= '0;
            r_sh_err   <= 1'b0;
            r_sh_to    <= 1'b0;
            r_state    <= S_STABLE;
          end
        end
        S_STABLE: begin
          r_to_cnt <= r_to_cnt + 1'b1;
          if (r_to_cnt == TO_LAST) begin
            r_sh_to    <= 1'b1;
            r_sh_err   <= 1'b1;
            r_sh_value <= '0;
            r_sh_mask  <= '0;
            r_state    <= S_DONE;
          end else if (i_seg_in == r_snap) begin
            if (r_stab_cnt == ST_LAST) begin
              r_idx   <= '0;
              r_state <= S_SCAN;
            end else begin
              r_stab_cnt <= r_stab_cnt + 1'b1;
            end
          end else begin
            r_snap     <= i_seg_in;
            r_stab_cnt <= '0;
          end
        end
        S_SCAN: begin
          r_sh_value[r_idx*4 +: 4] <= w_nib;
          r_sh_mask[r_idx]         <= w_legal;
          if (!w_legal && !w_blank) r_sh_err <= 1'b1;
          if (r_idx == IDX_LAST) r_state <= S_DONE;
          else                   r_idx   <= r_idx + 1'b1;
        end
        S_DONE: begin
          r_done       <= 1'b1;
          r_value      <= r_sh_value;
          r_valid_mask <= r_sh_mask;
          r_error      <= r_sh_err;
          r_timeout    <= r_sh_to;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_value      = r_value;
  assign o_valid_mask = r_valid_mask;
  assign o_error      = r_error;
  assign o_timeout    = r_timeout;

endmodule
